// File: rtl/fp_add_pkg.sv
// Shared types and constants for the fp_add_arbiter slice: operand width,
// sequencer state encoding, operand bundle and a few IEEE-754 helpers.
package fp_add_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Handy single-precision constants
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F800000;
    localparam logic [FP_W-1:0] FP_HALF = 32'h3F000000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_op_t;

    function automatic logic fp_is_nan(input logic [FP_W-1:0] v);
        return (&v[30:23]) & (|v[22:0]);
    endfunction

    function automatic logic fp_is_inf(input logic [FP_W-1:0] v);
        return (&v[30:23]) & ~(|v[22:0]);
    endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// rr_pick: round-robin priority picker. Searches req upward from ptr,
// wrapping at NUM_REQ, and returns the first hit one-hot plus its index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] j;

    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // walk from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = ID_W'(wrap(int'(ptr) + k));
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/fp_adder.sv
// fp_adder: combinational IEEE-754 single-precision adder, round to nearest
// even, full subnormal support. overflow = finite operands rounded to Inf;
// underflow = result is subnormal. NaN/Inf operands follow IEEE rules.
module fp_adder
    import fp_add_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] sum,
    output logic            overflow,
    output logic            underflow
);

    logic            swap, eff_sub;
    logic [FP_W-1:0] x, y;
    logic [7:0]      ex, ey, d;
    logic [4:0]      dd;
    logic [23:0]     mx, my;
    logic [49:0]     wide;
    logic [26:0]     xal, yal;
    logic [27:0]     raw;
    logic [4:0]      lz;
    logic [7:0]      nsh;
    logic [26:0]     norm;
    logic [9:0]      e_norm, fld;
    logic            rnd_up;
    logic [24:0]     mr;
    logic [22:0]     frac;

    // x is always the larger magnitude so the difference never goes negative
    assign swap = b[30:0] > a[30:0];
    assign x    = swap ? b : a;
    assign y    = swap ? a : b;

    // subnormals use exponent 1 with no hidden bit
    assign ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    assign ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    assign mx = {x[30:23] != 8'd0, x[22:0]};
    assign my = {y[30:23] != 8'd0, y[22:0]};

    // align y: 24 mantissa bits + guard + round + sticky; beyond 26 places y is pure sticky
    assign d    = ex - ey;
    assign dd   = (d > 8'd26) ? 5'd26 : d[4:0];
    assign wide = {my, 26'd0} >> dd;
    assign xal  = {mx, 3'b000};
    assign yal  = {wide[49:24], |wide[23:0]};

    assign eff_sub = x[31] ^ y[31];
    assign raw     = eff_sub ? ({1'b0, xal} - {1'b0, yal})
                             : ({1'b0, xal} + {1'b0, yal});

    // leading-zero count of the uncarried 27-bit magnitude
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (raw[i]) lz = 5'(26 - i);
    end

    // carry shifts right one place; cancellation shifts left but never below exponent 1
    always_comb begin
        nsh    = 8'd0;
        norm   = raw[26:0];
        e_norm = {2'b00, ex};
        if (raw[27]) begin
            norm   = {raw[27:2], raw[1] | raw[0]};
            e_norm = {2'b00, ex} + 10'd1;
        end else begin
            nsh    = ({3'b000, lz} > (ex - 8'd1)) ? (ex - 8'd1) : {3'b000, lz};
            norm   = raw[26:0] << nsh;
            e_norm = {2'b00, ex} - {2'b00, nsh};
        end
    end

    // round to nearest even; a mantissa carry bumps the exponent, a missing
    // hidden bit means the result stayed subnormal
    assign rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mr     = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    assign fld    = mr[24] ? (e_norm + 10'd1) : (mr[23] ? e_norm : 10'd0);
    assign frac   = mr[24] ? mr[23:1] : mr[22:0];

    // specials first, then exact zero, then overflow to Inf
    always_comb begin
        sum       = {x[31], fld[7:0], frac};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (fp_is_nan(a) || fp_is_nan(b) ||
            (fp_is_inf(a) && fp_is_inf(b) && (a[31] ^ b[31]))) begin
            sum = FP_QNAN;
        end else if (fp_is_inf(a)) begin
            sum = a;
        end else if (fp_is_inf(b)) begin
            sum = b;
        end else if (raw == 28'd0) begin
            sum = {x[31] & y[31], 31'd0};
        end else if (fld >= 10'd255) begin
            sum      = {x[31], 8'hFF, 23'd0};
            overflow = 1'b1;
        end else begin
            underflow = (fld == 10'd0);
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one fp_adder among NUM_REQ requesters with
// round-robin grants. One op in flight: IDLE (grant) -> CALC (adder) ->
// RESP (hold result until taken).
// Optional build macro FP_ADD_ARBITER_STATS_EN adds saturating counters
// stat_ops / stat_ovf / stat_udf of completed responses.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_sum,
    output logic                    rsp_overflow,
    output logic                    rsp_underflow,
    input  logic                    rsp_ready
`ifdef FP_ADD_ARBITER_STATS_EN
    ,
    output logic [31:0]             stat_ops,
    output logic [15:0]             stat_ovf,
    output logic [15:0]             stat_udf
`endif
);

    state_t                          state;
    logic [ID_W-1:0]                 rr_ptr, owner, g_idx;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0][FP_W-1:0]    a_vec, b_vec;
    fp_op_t                          op;
    logic [FP_W-1:0]                 add_sum;
    logic                            add_ovf, add_udf;
    logic                            hs;

    assign a_vec = req_a;
    assign b_vec = req_b;
    assign hs    = rsp_valid & rsp_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g_idx)
    );

    // grants are only offered while idle and out of reset
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;

    fp_adder u_add (
        .a         (op.a),
        .b         (op.b),
        .sum       (add_sum),
        .overflow  (add_ovf),
        .underflow (add_udf)
    );

    // sequencer: latch the granted operands, give the adder one cycle, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            op            <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_sum       <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op.a   <= a_vec[g_idx];
                        op.b   <= b_vec[g_idx];
                        owner  <= g_idx;
                        rr_ptr <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum       <= add_sum;
                    rsp_overflow  <= add_ovf;
                    rsp_underflow <= add_udf;
                    rsp_id        <= owner;
                    rsp_valid     <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (hs) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_ADD_ARBITER_STATS_EN
    // saturating counts of completed responses and of their raised flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
            stat_udf <= '0;
        end else if (hs) begin
            if (~&stat_ops)                  stat_ops <= stat_ops + 32'd1;
            if (rsp_overflow  && ~&stat_ovf) stat_ovf <= stat_ovf + 16'd1;
            if (rsp_underflow && ~&stat_udf) stat_udf <= stat_udf + 16'd1;
        end
    end
`endif

endmodule
